// File: rtl/ccom_pkg.sv
// ccom shared definitions: frame geometry, fixed-point scaling,
// controller states and the shift/saturate helper.
package ccom_pkg;

  localparam int DW    = 12;
  localparam int NFFT  = 512;
  localparam int NSYM  = 7;
  localparam int NFRM  = NSYM * NFFT;
  localparam int SHIFT = 10;

  localparam int AW = $clog2(NFRM);
  localparam int HW = $clog2(NFFT);
  localparam int CW = $clog2(NFRM + 1);
  localparam int KW = $clog2(NFFT + 1);
  localparam int PW = 2 * DW + 1;

  typedef enum logic {
    LOAD,
    OUT
  } state_t;

  // Floor-shift a full-precision sum, then clamp to the DW-bit range.
  function automatic logic signed [DW-1:0] sat_shift(
    input logic signed [PW-1:0] x
  );
    logic signed [PW-1:0] s;
    logic [PW-DW:0] top;
    s   = x >>> SHIFT;
    top = s[PW-1:DW-1];
    if (top == '0 || top == '1)
      return s[DW-1:0];
    else if (s[PW-1])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

endpackage

// File: rtl/ccom_cmul.sv
// ccom_cmul: s * conj(h), product stage then sum/shift/saturate.
// Outputs hold their value while out_vld is low.
module ccom_cmul
  import ccom_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic signed [DW-1:0] s_re,
  input  logic signed [DW-1:0] s_im,
  input  logic signed [DW-1:0] h_re,
  input  logic signed [DW-1:0] h_im,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 out_vld
);

  logic signed [2*DW-1:0] p_rr;
  logic signed [2*DW-1:0] p_ii;
  logic signed [2*DW-1:0] p_ir;
  logic signed [2*DW-1:0] p_ri;
  logic                   p_vld;
  logic signed [PW-1:0]   re_sum;
  logic signed [PW-1:0]   im_sum;

  // Register the four partial products of the conjugate multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rr  <= '0;
      p_ii  <= '0;
      p_ir  <= '0;
      p_ri  <= '0;
      p_vld <= 1'b0;
    end else begin
      p_vld <= in_vld;
      p_rr  <= (2*DW)'(s_re) * (2*DW)'(h_re);
      p_ii  <= (2*DW)'(s_im) * (2*DW)'(h_im);
      p_ir  <= (2*DW)'(s_im) * (2*DW)'(h_re);
      p_ri  <= (2*DW)'(s_re) * (2*DW)'(h_im);
    end
  end

  // Full-precision sums, one guard bit above the products.
  always_comb begin
    re_sum = $signed({p_rr[2*DW-1], p_rr})
           + $signed({p_ii[2*DW-1], p_ii});
    im_sum = $signed({p_ir[2*DW-1], p_ir})
           - $signed({p_ri[2*DW-1], p_ri});
  end

  // Output register: scale, clamp, hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_re  <= '0;
      out_im  <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= p_vld;
      if (p_vld) begin
        out_re <= sat_shift(re_sum);
        out_im <= sat_shift(im_sum);
      end
    end
  end

endmodule

// File: rtl/ccom.sv
// ccom: buffer one frame plus channel estimate, then stream out
// each sample phase-compensated by conj(H[k]).
module ccom
  import ccom_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din_sp_re,
  input  logic signed [DW-1:0] din_sp_im,
  input  logic                 din_sp_vld,
  input  logic signed [DW-1:0] din_H_re,
  input  logic signed [DW-1:0] din_H_im,
  input  logic                 din_H_vld,
  output logic signed [DW-1:0] dout_re,
  output logic signed [DW-1:0] dout_im,
  output logic                 dout_vld
);

  localparam logic [CW-1:0] SP_FULL = CW'(NFRM);
  localparam logic [KW-1:0] H_FULL  = KW'(NFFT);
  localparam logic [AW-1:0] RD_LAST = AW'(NFRM - 1);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   sp_cnt;
  logic [KW-1:0]   h_cnt;
  logic [AW-1:0]   rd_idx;
  logic            rd_vld;
  logic            full;
  logic            sp_we;
  logic            h_we;
  logic [2*DW-1:0] sp_ram [NFRM];
  logic [2*DW-1:0] h_ram  [NFFT];
  logic [2*DW-1:0] sp_q;
  logic [2*DW-1:0] h_q;

  assign full  = (sp_cnt == SP_FULL) && (h_cnt == H_FULL);
  assign sp_we = (state == LOAD) && din_sp_vld && (sp_cnt != SP_FULL);
  assign h_we  = (state == LOAD) && din_H_vld && (h_cnt != H_FULL);

  // Next state: fill until both buffers are full, then one output pass.
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD: if (full) state_nx = OUT;
      OUT:  if (rd_idx == RD_LAST) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  // Write counters, read index and read-valid tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_cnt <= '0;
      h_cnt  <= '0;
      rd_idx <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= (state == OUT);
      if (state == LOAD && full) begin
        sp_cnt <= '0;
        h_cnt  <= '0;
        rd_idx <= '0;
      end else begin
        if (sp_we) sp_cnt <= sp_cnt + 1'b1;
        if (h_we)  h_cnt  <= h_cnt + 1'b1;
        if (state == OUT)
          rd_idx <= (rd_idx == RD_LAST) ? '0 : rd_idx + 1'b1;
      end
    end
  end

  // Sample and channel RAMs, synchronous read.
  always_ff @(posedge clk) begin
    if (sp_we) sp_ram[sp_cnt[AW-1:0]] <= {din_sp_re, din_sp_im};
    if (h_we)  h_ram[h_cnt[HW-1:0]]   <= {din_H_re, din_H_im};
    sp_q <= sp_ram[rd_idx];
    h_q  <= h_ram[rd_idx[HW-1:0]];
  end

  ccom_cmul u_cmul (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_vld),
    .s_re    (sp_q[2*DW-1:DW]),
    .s_im    (sp_q[DW-1:0]),
    .h_re    (h_q[2*DW-1:DW]),
    .h_im    (h_q[DW-1:0]),
    .out_re  (dout_re),
    .out_im  (dout_im),
    .out_vld (dout_vld)
  );

endmodule

// File: tb/tb_ccom.sv
// tb_ccom: directed frames for ccom, expected samples queued at
// issue time and checked by a monitor on the falling edge.
module tb_ccom;
  import ccom_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [DW-1:0] din_sp_re = '0;
  logic signed [DW-1:0] din_sp_im = '0;
  logic                 din_sp_vld = 1'b0;
  logic signed [DW-1:0] din_H_re = '0;
  logic signed [DW-1:0] din_H_im = '0;
  logic                 din_H_vld = 1'b0;
  logic signed [DW-1:0] dout_re;
  logic signed [DW-1:0] dout_im;
  logic                 dout_vld;

  ccom dut (
    .clk        (clk),
    .rst        (rst),
    .din_sp_re  (din_sp_re),
    .din_sp_im  (din_sp_im),
    .din_sp_vld (din_sp_vld),
    .din_H_re   (din_H_re),
    .din_H_im   (din_H_im),
    .din_H_vld  (din_H_vld),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_vld   (dout_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2*DW-1:0] q[$];
  logic [2*DW-1:0] e;
  int checks = 0;
  int passed = 0;
  int nout = 0;
  int starts = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic prev_vld = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic logic [2*DW-1:0] pk(input int re, input int im);
    return {12'(re), 12'(im)};
  endfunction

  function automatic logic [2*DW-1:0] sp_val(input int mode, input int n);
    if (mode == 0) return pk(1024, 0);
    if (mode == 1) begin
      case (n % 4)
        0: return pk(0, 512);
        1: return pk(-1024, 0);
        2: return pk(2047, 2047);
        default: return pk(-2048, 0);
      endcase
    end
    return pk(n % 512, 0);
  endfunction

  function automatic logic [2*DW-1:0] h_val(input int mode, input int k);
    if (mode == 0) return pk(1024, 0);
    if (mode == 1) begin
      case (k % 4)
        0: return pk(0, 1024);
        1: return pk(1024, 0);
        2: return pk(2047, -2047);
        default: return pk(2047, 0);
      endcase
    end
    return (k == 5) ? pk(1024, 1024) : pk(1024, 0);
  endfunction

  // Hand-derived results for each directed pattern.
  function automatic logic [2*DW-1:0] exp_val(input int mode, input int n);
    if (mode == 0) return pk(1024, 0);
    if (mode == 1) begin
      case (n % 4)
        0: return pk(512, 0);
        1: return pk(-1024, 0);
        2: return pk(0, 2047);
        default: return pk(-2048, 0);
      endcase
    end
    return pk(n % 512, (n % 512 == 5) ? -5 : 0);
  endfunction

  always @(negedge clk) begin
    if (dout_vld && !rst) begin
      if (!prev_vld) begin
        starts++;
        first_cyc = cyc;
      end
      nout++;
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = q.pop_front();
        chk("dout_re", int'(dout_re), int'($signed(e[2*DW-1:DW])));
        chk("dout_im", int'(dout_im), int'($signed(e[DW-1:0])));
      end
    end
    prev_vld = dout_vld;
  end

  task automatic drive_frame(input int mode, input bit h_first,
                             input int extra);
    int total;
    int si;
    for (int n = 0; n < NFRM; n++) q.push_back(exp_val(mode, n));
    nout = 0;
    starts = 0;
    total = (h_first ? NFFT : 0) + NFRM + extra;
    for (int c = 0; c < total; c++) begin
      @(posedge clk);
      #1;
      si = h_first ? c - NFFT : c;
      din_H_vld = (c < NFFT);
      if (c < NFFT) {din_H_re, din_H_im} = h_val(mode, c);
      din_sp_vld = (si >= 0);
      if (si >= 0 && si < NFRM)
        {din_sp_re, din_sp_im} = sp_val(mode, si);
      else
        {din_sp_re, din_sp_im} = pk(777, -777);
      if (si == NFRM - 1) last_cyc = cyc + 1;
    end
    @(posedge clk);
    #1;
    din_sp_vld = 1'b0;
    din_H_vld = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    for (int w = 0; w < NFRM + 100 && nout < NFRM; w++) @(posedge clk);
    repeat (10) @(posedge clk);
    chk({tag, "_count"}, nout, NFRM);
    chk({tag, "_runs"}, starts, 1);
    chk({tag, "_latency"}, first_cyc - last_cyc, 4);
    chk({tag, "_queue"}, q.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_vld", int'(dout_vld), 0);
    chk("rst_re", int'(dout_re), 0);
    chk("rst_im", int'(dout_im), 0);
    @(negedge clk);
    rst = 1'b0;

    drive_frame(0, 1'b0, 0);
    finish_frame("identity");
    drive_frame(1, 1'b0, 0);
    finish_frame("rotate_sat");
    drive_frame(2, 1'b0, 0);
    finish_frame("index");
    drive_frame(2, 1'b1, 10);
    finish_frame("hfirst_overflow");

    drive_frame(0, 1'b0, 0);
    for (int w = 0; w < 2 * NFRM && nout < 100; w++) begin
      @(negedge clk);
      #1;
    end
    chk("abort_point", nout, 100);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_vld", int'(dout_vld), 0);
    chk("async_rst_re", int'(dout_re), 0);
    chk("async_rst_im", int'(dout_im), 0);
    q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    chk("quiet_after_rst", int'(dout_vld), 0);

    drive_frame(1, 1'b0, 0);
    finish_frame("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ccom.md
Name: ccom

Overview:
- Channel compensation (equalisation) stage of the OFDM receiver, placed between the serial/parallel FFT output and the demapper.
- Buffers one frame of NSYM×NFFT frequency-domain samples and one NFFT-point channel estimate H.
- Streams out each sample multiplied by conj(H[k]), then scaled and saturated.
- Phase-only compensation (no |H|² division); downstream demapping is sign/threshold based.

Parameters:
- DW, 12, signed sample width of all data ports.
- NFFT, 512, subcarriers per symbol (power of two).
- NSYM, 7, OFDM symbols per frame; frame length NFRM = NSYM×NFFT = 3584.
- SHIFT, 10, arithmetic right shift applied to products (H is Q1.10-like, 1024 ≈ 1.0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din_sp_re  in  DW  signed data sample, real part.
- din_sp_im  in  DW  signed data sample, imag part.
- din_sp_vld  in  1  data sample valid.
- din_H_re  in  DW  signed channel estimate, real part.
- din_H_im  in  DW  signed channel estimate, imag part.
- din_H_vld  in  1  channel estimate valid.
- dout_re  out  DW  compensated sample, real part.
- dout_im  out  DW  compensated sample, imag part.
- dout_vld  out  1  output valid.

Behaviour:
- Reset, asynchronous, active-high:
  - dout_re, dout_im, dout_vld = 0.
  - Write counters cleared; state = LOAD.
  - RAM contents undefined.
- All signed values are two's complement.
- LOAD state:
  - Each cycle with din_sp_vld=1 and sp_cnt<NFRM: write sample to SP RAM[sp_cnt], sp_cnt++.
  - Each cycle with din_H_vld=1 and h_cnt<NFFT: write to H RAM[h_cnt], h_cnt++.
  - Both streams may be valid in the same cycle; they are independent and may arrive in either order.
  - Valid samples beyond a full buffer are dropped.
- LOAD→OUT: on the edge after both sp_cnt==NFRM and h_cnt==NFFT.
  - rd_idx=0; both write counters cleared.
- OUT state:
  - rd_idx increments every cycle from 0 to NFRM-1, issuing reads of SP[rd_idx] and H[rd_idx mod NFFT].
  - All inputs are ignored (dropped) while in OUT.
  - After issuing NFRM-1, return to LOAD.
- Pipeline, synchronous-read RAMs:
  - Stage 1: RAM read.
  - Stage 2: four DW×DW signed products registered.
  - Stage 3: sum, shift, saturate, output register.
  - dout_vld is high exactly NFRM consecutive cycles, first assertion 3 cycles after the first read is issued.
  - Output order equals input order; output sample n uses H[n mod NFFT].
- Arithmetic, with s = sp, h = H:
  - re = s_re·h_re + s_im·h_im; im = s_im·h_re − s_re·h_im, each 2·DW+1 bits, full precision.
  - Arithmetic shift right by SHIFT (truncation toward −∞), then saturate to [−2^(DW−1), 2^(DW−1)−1].
- dout_re/dout_im hold their last value when dout_vld=0.
- Reset during OUT: outputs clear immediately; a partially loaded or partially output frame is discarded.

Decomposition:
- Shared package: DW, NFFT, NSYM, NFRM, SHIFT; state encoding LOAD/OUT.
- One natural sub-module: ccom_cmul (pipelined conj-multiply, shift and saturate, 2 stages).
- RAMs inferred in the top level.

Test Plan:
- Identity: all 3584 sp = (1024,0), all 512 H = (1024,0) -> 3584 outputs (1024,0), dout_vld contiguous, first 3 cycles after OUT entry.
- Phase rotation: sp=(0,512), H=(0,1024) -> output (512,0); sp=(−1024,0), H=(1024,0) -> (−1024,0).
- Saturation: sp=(2047,2047), H=(2047,−2047) -> im=8184 before clamp -> output (0,2047); sp=(−2048,0), H=(2047,0) -> (−4094 clamps to −2048, 0).
- Indexing: sp[n]=(n mod 512,0), H[k]=(1024,0) except H[5]=(2048>>1=1024,1024) -> outputs n mod 512, with k=5 slots showing imag −(5·1024)>>10=−5 in each of 7 symbols.
- Ordering/overflow: H sent before sp, then 10 extra sp samples -> identical output to normal order, extras dropped, exactly 3584 valid outputs.
- Reset mid-OUT at output 100 -> dout_vld=0 asynchronously; a fresh frame afterwards produces a correct full 3584-sample output.
